gol_gen_scheduler: RTL and testbench

//   Sequences one Game-of-Life generation across NUM_TILES array tiles: per tile LOAD -> STEP -> STORE.

---
 rtl/gol_sched_pkg.sv | 27 ++
 rtl/gol_down_counter.sv | 30 +++
 rtl/gol_gen_scheduler.sv | 131 +++++++++++++
 tb/tb_gol_gen_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_sched_pkg.sv
// Shared state encoding, widths and constant helpers for the generation scheduler.
package gol_sched_pkg;

   localparam int unsigned GEN_W = 16;
   localparam int unsigned ST_W  = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_STEP  = 3'd2,
      ST_STORE = 3'd3,
      ST_NEXT  = 3'd4,
      ST_GAP   = 3'd5
   } sched_state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

   function automatic int unsigned umax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gol_down_counter.sv
// Loadable down-counter that stops at zero; the zero flag is registered alongside the count.
module gol_down_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ld_i,
   input  logic [W-1:0] ld_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic         zero_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else if (ld_i) begin
         cnt_q  <= ld_val_i;
         zero_q <= (ld_val_i == '0);
      end else if (!zero_q) begin
         cnt_q  <= cnt_q - W'(1);
         zero_q <= (cnt_q == W'(1));
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/gol_gen_scheduler.sv
// Sequences LOAD -> STEP -> STORE over all tiles for one Game-of-Life generation.
// Define SCHED_WATCHDOG_EN to abort stalled handshakes into a sticky err flag.
module gol_gen_scheduler
   import gol_sched_pkg::*;
#(
   parameter int unsigned NUM_TILES   = 4,
   parameter int unsigned TILE_W      = 2,
   parameter int unsigned STEP_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 100000000,
   parameter int unsigned WDOG_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_en,
   input  logic              step_req,
   output logic              load_req,
   input  logic              load_ack,
   output logic              step_pulse,
   output logic              store_req,
   input  logic              store_ack,
   output logic [TILE_W-1:0] tile_idx,
   output logic [GEN_W-1:0]  gen_count,
   output logic              busy,
   output logic              frame_done,
   output logic              err
);

   localparam int unsigned MAX_CYC = umax(umax(STEP_CYCLES, GAP_CYCLES), WDOG_CYCLES);
   localparam int unsigned TMR_W   = (clog2(MAX_CYC) == 0) ? 1 : clog2(MAX_CYC);

   localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);
   localparam logic [TMR_W-1:0]  STEP_LD   = TMR_W'(STEP_CYCLES - 1);
   localparam logic [TMR_W-1:0]  GAP_LD    = TMR_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0]  WDOG_LD   = TMR_W'(WDOG_CYCLES - 1);

   sched_state_e      state_q, state_d;
   logic [TILE_W-1:0] tile_idx_q;
   logic [GEN_W-1:0]  gen_count_q;
   logic              load_req_q, step_pulse_q, store_req_q, busy_q, frame_done_q;
   logic              err_q;
   logic              wdog_trip_c;
   logic              tmr_ld_c;
   logic [TMR_W-1:0]  tmr_val_c;
   logic              tmr_zero;

   // Shared timer: reloaded on every state change, value chosen by the state being entered.
   gol_down_counter #(.W(TMR_W)) u_tmr (
      .clk      (clk),
      .reset    (reset),
      .ld_i     (tmr_ld_c),
      .ld_val_i (tmr_val_c),
      .zero_o   (tmr_zero)
   );

`ifdef SCHED_WATCHDOG_EN
   assign wdog_trip_c = tmr_zero &&
                        ((load_req_q && !load_ack) || (store_req_q && !store_ack));

   always_ff @(posedge clk) begin
      if (!reset)           err_q <= 1'b0;
      else if (wdog_trip_c) err_q <= 1'b1;
   end
`else
   assign wdog_trip_c = 1'b0;
   assign err_q       = 1'b0;
`endif

   // Next-state selection; the watchdog overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if ((run_en || step_req) && !err_q) state_d = ST_LOAD;
         ST_LOAD:  if (load_req_q && load_ack) state_d = ST_STEP;
         ST_STEP:  if (tmr_zero) state_d = ST_STORE;
         ST_STORE: if (store_req_q && store_ack)
                      state_d = (tile_idx_q == LAST_TILE) ? ST_NEXT : ST_LOAD;
         ST_NEXT:  state_d = run_en ? ST_GAP : ST_IDLE;
         ST_GAP: begin
            if (!run_en)       state_d = ST_IDLE;
            else if (tmr_zero) state_d = ST_LOAD;
         end
         default:  state_d = ST_IDLE;
      endcase
      if (wdog_trip_c) state_d = ST_IDLE;

      tmr_ld_c = (state_d != state_q);
      case (state_d)
         ST_STEP:           tmr_val_c = STEP_LD;
         ST_GAP:            tmr_val_c = GAP_LD;
         ST_LOAD, ST_STORE: tmr_val_c = WDOG_LD;
         default:           tmr_val_c = '0;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         tile_idx_q   <= '0;
         gen_count_q  <= '0;
         load_req_q   <= 1'b0;
         step_pulse_q <= 1'b0;
         store_req_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_req_q   <= (state_d == ST_LOAD);
         step_pulse_q <= (state_d == ST_STEP);
         store_req_q  <= (state_d == ST_STORE);
         busy_q       <= (state_d != ST_IDLE);
         frame_done_q <= (state_d == ST_NEXT);
         if (state_q == ST_STORE && state_d == ST_LOAD)
            tile_idx_q <= tile_idx_q + TILE_W'(1);
         else if (state_q == ST_NEXT || state_d == ST_IDLE)
            tile_idx_q <= '0;
         if (state_q == ST_STORE && state_d == ST_NEXT)
            gen_count_q <= gen_count_q + GEN_W'(1);
      end
   end

   assign load_req   = load_req_q;
   assign step_pulse = step_pulse_q;
   assign store_req  = store_req_q;
   assign tile_idx   = tile_idx_q;
   assign gen_count  = gen_count_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Directed bench for gol_gen_scheduler: vector table plus multi-cycle sequences.
// Watchdog expectations follow SCHED_WATCHDOG_EN.
module tb_gol_gen_scheduler;

   localparam int unsigned NUM_TILES   = 4;
   localparam int unsigned TILE_W      = 2;
   localparam int unsigned STEP_CYCLES = 16;
   localparam int unsigned GAP_CYCLES  = 20;
   localparam int unsigned WDOG_CYCLES = 64;
   localparam int          ACK_DLY     = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic run_en = 1'b0;
   logic step_req = 1'b0;
   logic load_req, step_pulse, store_req, busy, frame_done, err;
   logic load_ack, store_ack;
   logic [TILE_W-1:0] tile_idx;
   logic [15:0]       gen_count;

   logic man_load_ack = 1'b0, man_store_ack = 1'b0;
   logic rsp_load_ack = 1'b0, rsp_store_ack = 1'b0;
   logic rsp_load_en = 1'b0, rsp_store_en = 1'b0;
   int   hold_store_tile = -1;
   int   lcnt = 0, scnt = 0;

   int errors = 0;
   int checks = 0;

   int n_load_hs, n_store_hs, n_frames, run_len, gap_cnt;
   bit gap_on;
   int step_runs[$];
   int gaps[$];
   int tiles[$];

   assign load_ack  = man_load_ack  | rsp_load_ack;
   assign store_ack = man_store_ack | rsp_store_ack;

   gol_gen_scheduler #(
      .NUM_TILES   (NUM_TILES),
      .TILE_W      (TILE_W),
      .STEP_CYCLES (STEP_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES),
      .WDOG_CYCLES (WDOG_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run_en     (run_en),
      .step_req   (step_req),
      .load_req   (load_req),
      .load_ack   (load_ack),
      .step_pulse (step_pulse),
      .store_req  (store_req),
      .store_ack  (store_ack),
      .tile_idx   (tile_idx),
      .gen_count  (gen_count),
      .busy       (busy),
      .frame_done (frame_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Array/memory model: one-cycle ack ACK_DLY cycles after each request rises.
   always @(posedge clk) begin
      #2;
      if (load_req && rsp_load_en) begin
         lcnt++;
         rsp_load_ack = (lcnt == ACK_DLY);
      end else begin
         lcnt = 0;
         rsp_load_ack = 1'b0;
      end
      if (store_req && rsp_store_en && (hold_store_tile < 0 || int'(tile_idx) != hold_store_tile)) begin
         scnt++;
         rsp_store_ack = (scnt == ACK_DLY);
      end else begin
         scnt = 0;
         rsp_store_ack = 1'b0;
      end
   end

   // Mid-cycle observer: handshakes, tile order, step run lengths, gap lengths.
   always @(negedge clk) begin
      if (load_req && load_ack) begin
         n_load_hs++;
         tiles.push_back(int'(tile_idx));
      end
      if (store_req && store_ack) n_store_hs++;
      if (frame_done) n_frames++;
      if (step_pulse) run_len++;
      else if (run_len > 0) begin
         step_runs.push_back(run_len);
         run_len = 0;
      end
      if (frame_done) begin
         gap_on  = 1'b1;
         gap_cnt = 0;
      end else if (gap_on) begin
         if (load_req) begin
            gaps.push_back(gap_cnt);
            gap_on = 1'b0;
         end else if (!busy) gap_on = 1'b0;
         else gap_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      n_load_hs = 0; n_store_hs = 0; n_frames = 0; run_len = 0;
      gap_on = 1'b0; gap_cnt = 0;
      step_runs.delete(); gaps.delete(); tiles.delete();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic pulse_step();
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check(name, 64'(busy), 64'd0);
   endtask

   // {run_en, step_req, load_ack, store_ack} then {load_req, step_pulse, store_req, busy}, tile.
   typedef struct packed {
      logic       run_en;
      logic       step_req;
      logic       load_ack;
      logic       store_ack;
      logic       load_req;
      logic       step_pulse;
      logic       store_req;
      logic       busy;
      logic [1:0] tile;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int cnt;
      vecs[0] = {4'b0000, 4'b0000, 2'd0};  // idle, nothing asserted
      vecs[1] = {4'b0001, 4'b0000, 2'd0};  // store_ack in IDLE ignored
      vecs[2] = {4'b0010, 4'b0000, 2'd0};  // load_ack in IDLE ignored
      vecs[3] = {4'b0100, 4'b1001, 2'd0};  // step_req -> LOAD tile 0
      vecs[4] = {4'b0110, 4'b0101, 2'd0};  // step_req ignored; ack with fresh req -> STEP
      vecs[5] = {4'b0010, 4'b0101, 2'd0};  // load_ack in STEP ignored
      vecs[6] = {4'b0001, 4'b0101, 2'd0};  // store_ack in STEP ignored
      vecs[7] = {4'b0100, 4'b0101, 2'd0};  // step_req while busy ignored
      vecs[8] = {4'b0000, 4'b0101, 2'd0};

      do_reset();
      check("reset_outputs",
            64'({load_req, step_pulse, store_req, busy, frame_done, err, tile_idx, gen_count}), 64'd0);

      // Spurious acks and step_req while busy
      clear_mon();
      for (int i = 0; i < 9; i++) begin
         run_en        = vecs[i].run_en;
         step_req      = vecs[i].step_req;
         man_load_ack  = vecs[i].load_ack;
         man_store_ack = vecs[i].store_ack;
         tick();
         check($sformatf("vec%0d", i),
               64'({load_req, step_pulse, store_req, busy, tile_idx}),
               64'({vecs[i].load_req, vecs[i].step_pulse, vecs[i].store_req, vecs[i].busy, vecs[i].tile}));
      end
      run_en = 1'b0; step_req = 1'b0; man_load_ack = 1'b0; man_store_ack = 1'b0;
      rsp_load_en = 1'b1;
      rsp_store_en = 1'b1;
      wait_idle("spur_idle_timeout", 400);
      check("spur_gen_count", 64'(gen_count), 64'd1);
      check("spur_load_hs", 64'(n_load_hs), 64'd4);
      repeat (5) tick();
      check("spur_no_second_gen", 64'({busy, gen_count}), 64'd1);

      // Single step
      do_reset();
      clear_mon();
      pulse_step();
      wait_idle("t1_idle_timeout", 400);
      check("t1_tile_count", 64'(tiles.size()), 64'd4);
      for (int i = 0; i < tiles.size(); i++)
         check($sformatf("t1_tile%0d", i), 64'(tiles[i]), 64'(i));
      check("t1_load_hs", 64'(n_load_hs), 64'd4);
      check("t1_store_hs", 64'(n_store_hs), 64'd4);
      check("t1_step_runs", 64'(step_runs.size()), 64'd4);
      for (int i = 0; i < step_runs.size(); i++)
         check($sformatf("t1_step_len%0d", i), 64'(step_runs[i]), 64'(STEP_CYCLES));
      check("t1_frames", 64'(n_frames), 64'd1);
      check("t1_gen_count", 64'(gen_count), 64'd1);
      check("t1_quiet", 64'({load_req, step_pulse, store_req, frame_done, tile_idx}), 64'd0);

      // Free-run, then drop run_en mid-STEP
      do_reset();
      clear_mon();
      run_en = 1'b1;
      cnt = 0;
      while (n_frames < 3 && cnt < 1000) begin
         tick();
         cnt++;
      end
      check("t2_frames3", 64'(n_frames), 64'd3);
      check("t2_gen_count3", 64'(gen_count), 64'd3);
      cnt = 0;
      while (!step_pulse && cnt < 200) begin
         tick();
         cnt++;
      end
      check("t2_in_step", 64'(step_pulse), 64'd1);
      run_en = 1'b0;
      wait_idle("t2_idle_timeout", 400);
      check("t2_gen_count4", 64'(gen_count), 64'd4);
      check("t2_store_hs", 64'(n_store_hs), 64'd16);
      check("t2_gap_count", 64'(gaps.size()), 64'd3);
      for (int i = 0; i < gaps.size(); i++)
         check($sformatf("t2_gap%0d", i), 64'(gaps[i]), 64'(GAP_CYCLES));

      // Reset during STORE of tile 2
      clear_mon();
      hold_store_tile = 2;
      pulse_step();
      cnt = 0;
      while (!(store_req && tile_idx == 2'd2) && cnt < 300) begin
         tick();
         cnt++;
      end
      tick();
      tick();
      check("t3_store_held", 64'({store_req, tile_idx}), 64'({1'b1, 2'd2}));
      reset = 1'b0;
      tick();
      check("t3_reset_outputs",
            64'({load_req, step_pulse, store_req, busy, frame_done, err, tile_idx, gen_count}), 64'd0);
      reset = 1'b1;
      hold_store_tile = -1;
      man_store_ack = 1'b1;
      tick();
      man_store_ack = 1'b0;
      tick();
      check("t3_late_ack_ignored",
            64'({load_req, store_req, busy, frame_done, gen_count}), 64'd0);

      // gen_count wrap
      force dut.gen_count_q = 16'hFFFF;
      tick();
      release dut.gen_count_q;
      clear_mon();
      pulse_step();
      wait_idle("t5_idle_timeout", 400);
      check("t5_gen_wrap", 64'(gen_count), 64'd0);
      check("t5_frames", 64'(n_frames), 64'd1);

      // Load handshake never acknowledged
      do_reset();
      rsp_load_en = 1'b0;
      pulse_step();
      cnt = 0;
      while (load_req && cnt < 100) begin
         cnt++;
         tick();
      end
`ifdef SCHED_WATCHDOG_EN
      check("t6_wdog_len", 64'(cnt), 64'(WDOG_CYCLES));
      check("t6_err_state", 64'({err, busy, load_req}), 64'({1'b1, 1'b0, 1'b0}));
      pulse_step();
      repeat (3) tick();
      check("t6_step_ignored", 64'({err, busy, load_req}), 64'({1'b1, 1'b0, 1'b0}));
`else
      check("t6_wait_forever", 64'(cnt), 64'd100);
      check("t6_no_err", 64'({err, busy, load_req}), 64'({1'b0, 1'b1, 1'b1}));
`endif
      do_reset();
      check("t6_err_cleared", 64'({err, busy}), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
